// File: rtl/rd_adc_pkg.sv
// rd_adc_pkg: types and helpers shared across the sigma-delta ADC stages.
//   state_t  : decimator window FSM states (IDLE / RUN / HOLD)
//   decim_dw : sample width for a 2^osr_log2 window; holds the values 0..M
package rd_adc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  // One more bit than log2(M) so an all-ones window (value M) fits.
  function automatic int decim_dw(input int osr_log2);
    return osr_log2 + 1;
  endfunction

endpackage

// File: rtl/rd_decim_outreg.sv
// rd_decim_outreg: holding register for decimated samples with a valid/ready
// handshake toward the sample consumer.
//   CLK, CLRbar         : clock, async active-high reset
//   load_req, sample    : one-cycle pulse with the finished window's sample
//   DREADY              : consumer takes DOUT on an edge with DVALID && DREADY
//   DOUT, DVALID        : registered sample and its valid flag
//   OVR                 : sticky drop flag (only when DECIM_OVERRUN_EN is defined)
// Configuration macro: DECIM_OVERRUN_EN.
module rd_decim_outreg #(
  parameter int DW = 9
) (
  input  logic          CLK,
  input  logic          CLRbar,
  input  logic          load_req,
  input  logic [DW-1:0] sample,
  input  logic          DREADY,
  output logic [DW-1:0] DOUT,
  output logic          DVALID
`ifdef DECIM_OVERRUN_EN
  ,
  output logic          OVR
`endif
);

  logic take, load;

  assign take = DVALID && DREADY;
  // A held sample that is accepted on this edge frees the slot for reload.
  assign load = load_req && (!DVALID || DREADY);

  always_ff @(posedge CLK or posedge CLRbar) begin
    if (CLRbar) begin
      DOUT   <= '0;
      DVALID <= 1'b0;
    end else if (load) begin
      DOUT   <= sample;
      DVALID <= 1'b1;
    end else if (take) begin
      // DOUT deliberately keeps its last value after acceptance.
      DVALID <= 1'b0;
    end
  end

`ifdef DECIM_OVERRUN_EN
  // Cleared only by reset; START does not touch it.
  always_ff @(posedge CLK or posedge CLRbar) begin
    if (CLRbar)
      OVR <= 1'b0;
    else if (load_req && DVALID && !DREADY)
      OVR <= 1'b1;
  end
`endif

endmodule

// File: rtl/rd_sd_decimator.sv
// rd_sd_decimator: sinc1 decimator; counts ones in the 1-bit modulator stream
// over windows of M = 2^OSR_LOG2 enabled clocks, one sample per window.
//   CLK, CLRbar   : clock, async active-high reset
//   BIT_IN        : modulator bit (registered upstream)
//   EN            : accumulate enable; low pauses the window
//   START         : one-cycle pulse discarding the partial window
//   DOUT, DVALID  : sample and valid; DREADY accepts it
//   OVR           : sticky overrun flag (only when DECIM_OVERRUN_EN is defined)
// Configuration macro: DECIM_OVERRUN_EN.
module rd_sd_decimator
  import rd_adc_pkg::*;
#(
  parameter  int OSR_LOG2 = 8,
  localparam int DW       = decim_dw(OSR_LOG2)
) (
  input  logic          CLK,
  input  logic          CLRbar,
  input  logic          BIT_IN,
  input  logic          EN,
  input  logic          START,
  input  logic          DREADY,
  output logic [DW-1:0] DOUT,
  output logic          DVALID
`ifdef DECIM_OVERRUN_EN
  ,
  output logic          OVR
`endif
);

  if (OSR_LOG2 < 2 || OSR_LOG2 > 12) begin : g_bad_osr
    $error("OSR_LOG2 must be in 2..12");
  end

  localparam logic [OSR_LOG2-1:0] CNT_LAST = '1;  // M-1

  state_t                state, state_nxt;
  logic [DW-1:0]         acc;
  logic [OSR_LOG2-1:0]   cnt;
  logic                  accum, win_end;
  logic [DW-1:0]         sample;

  // START outranks accumulation; EN alone decides whether an edge counts
  // (IDLE and HOLD both count the bit on the edge EN is seen high).
  assign accum   = EN && !START;
  assign win_end = accum && (cnt == CNT_LAST);
  assign sample  = acc + {{(DW-1){1'b0}}, BIT_IN};

  always_ff @(posedge CLK or posedge CLRbar) begin
    if (CLRbar) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (START) begin
      state_nxt = EN ? RUN : IDLE;
    end else begin
      case (state)
        IDLE:    if (EN)  state_nxt = RUN;
        RUN:     if (!EN) state_nxt = HOLD;
        HOLD:    if (EN)  state_nxt = RUN;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or posedge CLRbar) begin
    if (CLRbar) begin
      acc <= '0;
      cnt <= '0;
    end else if (START) begin
      acc <= '0;
      cnt <= '0;
    end else if (accum) begin
      acc <= win_end ? '0 : sample;
      cnt <= cnt + 1'b1;  // wraps to 0 at window end
    end
  end

  rd_decim_outreg #(.DW(DW)) u_outreg (
    .CLK      (CLK),
    .CLRbar   (CLRbar),
    .load_req (win_end),
    .sample   (sample),
    .DREADY   (DREADY),
    .DOUT     (DOUT),
    .DVALID   (DVALID)
`ifdef DECIM_OVERRUN_EN
    ,
    .OVR      (OVR)
`endif
  );

endmodule

// File: tb/tb_rd_sd_decimator.sv
// Bench for rd_sd_decimator at OSR_LOG2=4 (M=16, DW=5). A behavioural model
// tracks the number of ones seen in the current window and the consumer-side
// holding slot; scenario tasks compare the DUT against it and against fixed
// expected values. OVR checks are active when DECIM_OVERRUN_EN is defined.
module tb_rd_sd_decimator;
  localparam int OSR_LOG2 = 4;
  localparam int M  = 1 << OSR_LOG2;
  localparam int DW = OSR_LOG2 + 1;

  logic CLK = 1'b0, CLRbar = 1'b0;
  logic BIT_IN = 1'b0, EN = 1'b0, START = 1'b0, DREADY = 1'b0;
  logic [DW-1:0] DOUT;
  logic DVALID;
`ifdef DECIM_OVERRUN_EN
  logic OVR;
`endif

  int errors = 0, checks = 0;

  // model state
  int   m_ones, m_seen;
  int   m_dout;
  logic m_dvalid, m_ovr;

  always #5 CLK = ~CLK;

  rd_sd_decimator #(.OSR_LOG2(OSR_LOG2)) dut (
    .CLK(CLK), .CLRbar(CLRbar), .BIT_IN(BIT_IN), .EN(EN), .START(START),
    .DREADY(DREADY), .DOUT(DOUT), .DVALID(DVALID)
`ifdef DECIM_OVERRUN_EN
    , .OVR(OVR)
`endif
  );

  task automatic model_reset();
    m_ones = 0; m_seen = 0; m_dout = 0; m_dvalid = 1'b0; m_ovr = 1'b0;
  endtask

  // Drive one cycle of stimulus, advance the model by one edge, and return
  // #1 after the edge so callers can compare.
  task automatic step(input logic b, input logic en, input logic st, input logic rdy);
    bit have; int smp;
    @(negedge CLK);
    BIT_IN = b; EN = en; START = st; DREADY = rdy;
    @(posedge CLK);
    have = 0; smp = 0;
    if (st) begin
      m_ones = 0; m_seen = 0;
    end else if (en) begin
      m_ones += int'(b);
      m_seen += 1;
      if (m_seen == M) begin
        have = 1; smp = m_ones; m_ones = 0; m_seen = 0;
      end
    end
    if (have && m_dvalid && !rdy) m_ovr = 1'b1;
    else if (have) begin m_dout = smp; m_dvalid = 1'b1; end
    else if (m_dvalid && rdy) m_dvalid = 1'b0;
    #1;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    CLRbar = 1'b1; BIT_IN = 0; EN = 0; START = 0; DREADY = 0;
    @(negedge CLK);
    CLRbar = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (DOUT !== '0 || DVALID !== 1'b0) begin
      errors++; $display("FAIL reset: DOUT=%0d DVALID=%b, want 0/0", DOUT, DVALID);
    end
`ifdef DECIM_OVERRUN_EN
    checks++;
    if (OVR !== 1'b0) begin errors++; $display("FAIL reset_ovr: OVR=%b want 0", OVR); end
`endif
  endtask

  task automatic test_constant_ones();
    do_reset();
    for (int i = 1; i <= 3*M; i++) begin
      step(1, 1, 0, 1);
      if ((i % M) == 0) begin
        checks++;
        if (DVALID !== 1'b1 || DOUT !== 5'b10000) begin
          errors++; $display("FAIL ones_sample@%0d: DVALID=%b DOUT=%0d, want 1/16", i, DVALID, DOUT);
        end
      end else if (i < M) begin
        checks++;
        if (DVALID !== 1'b0) begin
          errors++; $display("FAIL ones_early@%0d: DVALID=%b, want 0", i, DVALID);
        end
      end
    end
  endtask

  task automatic test_alternating();
    do_reset();
    for (int i = 0; i < M; i++) step(logic'(~i[0]), 1, 0, 1);
    checks++;
    if (DVALID !== 1'b1 || DOUT !== 5'd8) begin
      errors++; $display("FAIL alt_sample: DVALID=%b DOUT=%0d, want 1/8", DVALID, DOUT);
    end
    for (int i = 0; i < M; i++) step(0, 1, 0, 1);
    checks++;
    if (DVALID !== 1'b1 || DOUT !== 5'd0) begin
      errors++; $display("FAIL zero_sample: DVALID=%b DOUT=%0d, want 1/0", DVALID, DOUT);
    end
  endtask

  task automatic test_en_pause();
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 1, 0, 1);
    for (int i = 0; i < 5; i++)  step(1, 0, 0, 1);
    for (int i = 0; i < 5; i++)  step(1, 1, 0, 1);
    checks++;
    if (DVALID !== 1'b0) begin
      errors++; $display("FAIL pause_early: DVALID=%b want 0 at edge 20", DVALID);
    end
    step(1, 1, 0, 1);
    checks++;
    if (DVALID !== 1'b1 || DOUT !== 5'd16) begin
      errors++; $display("FAIL pause_sample: DVALID=%b DOUT=%0d, want 1/16 at edge 21", DVALID, DOUT);
    end
  endtask

  task automatic test_overrun();
    do_reset();
    for (int i = 0; i < M; i++) step(logic'(i < 12), 1, 0, 0);
    checks++;
    if (DVALID !== 1'b1 || DOUT !== 5'd12) begin
      errors++; $display("FAIL ovr_first: DVALID=%b DOUT=%0d, want 1/12", DVALID, DOUT);
    end
    for (int i = 0; i < M; i++) step(logic'(i < 3), 1, 0, 0);
    checks++;
    if (DVALID !== 1'b1 || DOUT !== 5'd12) begin
      errors++; $display("FAIL ovr_hold: DVALID=%b DOUT=%0d, want 1/12", DVALID, DOUT);
    end
`ifdef DECIM_OVERRUN_EN
    checks++;
    if (OVR !== 1'b1) begin errors++; $display("FAIL ovr_set: OVR=%b want 1", OVR); end
`endif
    step(0, 0, 0, 1);
    checks++;
    if (DVALID !== 1'b0 || DOUT !== 5'd12) begin
      errors++; $display("FAIL ovr_accept: DVALID=%b DOUT=%0d, want 0/12", DVALID, DOUT);
    end
`ifdef DECIM_OVERRUN_EN
    checks++;
    if (OVR !== 1'b1) begin errors++; $display("FAIL ovr_sticky: OVR=%b want 1", OVR); end
`endif
  endtask

  task automatic test_start();
    do_reset();
    for (int i = 0; i < 10; i++) step(1, 1, 0, 1);
    step(1, 1, 1, 1);  // START with EN: bit not counted
    for (int i = 0; i < M-1; i++) step(1, 1, 0, 1);
    checks++;
    if (DVALID !== 1'b0) begin
      errors++; $display("FAIL start_early: DVALID=%b want 0", DVALID);
    end
    step(1, 1, 0, 1);
    checks++;
    if (DVALID !== 1'b1 || DOUT !== 5'd16) begin
      errors++; $display("FAIL start_sample: DVALID=%b DOUT=%0d, want 1/16", DVALID, DOUT);
    end
    for (int i = 0; i < M-1; i++) step(0, 1, 0, 1);
    step(1, 1, 1, 1);  // START on the would-be window end
    checks++;
    if (DVALID !== 1'b0) begin
      errors++; $display("FAIL start_vs_end: DVALID=%b want 0", DVALID);
    end
    for (int i = 0; i < M; i++) step(0, 1, 0, 1);
    checks++;
    if (DVALID !== 1'b1 || DOUT !== 5'd0) begin
      errors++; $display("FAIL start_after: DVALID=%b DOUT=%0d, want 1/0", DVALID, DOUT);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      step(logic'($urandom_range(1, 0)), logic'($urandom_range(7, 0) != 0),
           logic'($urandom_range(60, 0) == 0), logic'($urandom_range(3, 0) != 0));
      checks++;
      if (DVALID !== m_dvalid || (m_dvalid && DOUT !== m_dout[DW-1:0])) begin
        errors++;
        $display("FAIL random@%0d: DVALID=%b DOUT=%0d, want %b/%0d", i, DVALID, DOUT, m_dvalid, m_dout);
      end
`ifdef DECIM_OVERRUN_EN
      checks++;
      if (OVR !== m_ovr) begin
        errors++; $display("FAIL random_ovr@%0d: OVR=%b want %b", i, OVR, m_ovr);
      end
`endif
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < M; i++) step(1, 1, 0, 0);
    for (int i = 0; i < M; i++) step(1, 1, 0, 0);  // drop -> OVR
    for (int i = 0; i < 5; i++)  step(1, 1, 0, 0);  // mid-window
    checks++;
    if (DVALID !== 1'b1) begin
      errors++; $display("FAIL arst_pre: DVALID=%b want 1", DVALID);
    end
    #2 CLRbar = 1'b1;
    #1;
    checks++;
    if (DVALID !== 1'b0 || DOUT !== '0) begin
      errors++; $display("FAIL arst_now: DVALID=%b DOUT=%0d, want 0/0", DVALID, DOUT);
    end
`ifdef DECIM_OVERRUN_EN
    checks++;
    if (OVR !== 1'b0) begin errors++; $display("FAIL arst_ovr: OVR=%b want 0", OVR); end
`endif
    @(negedge CLK);
    CLRbar = 1'b0; EN = 0; DREADY = 0;
    model_reset();
    for (int i = 0; i < 20; i++) step(1, 0, 0, 0);
    checks++;
    if (DVALID !== 1'b0) begin
      errors++; $display("FAIL arst_idle: DVALID=%b want 0", DVALID);
    end
    for (int i = 0; i < M; i++) step(1, 1, 0, 0);
    checks++;
    if (DVALID !== 1'b1 || DOUT !== 5'd16) begin
      errors++; $display("FAIL arst_after: DVALID=%b DOUT=%0d, want 1/16", DVALID, DOUT);
    end
  endtask

  initial begin
    model_reset();
    CLRbar = 1'b1;
    #12;
    test_reset();
    test_constant_ones();
    test_alternating();
    test_en_pause();
    test_overrun();
    test_start();
    test_random();
    test_async_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rd_sd_decimator.md
# rd_sd_decimator

First-order (sinc1) decimator for the sigma-delta ADC path. It consumes the 1-bit modulator stream captured by the comparator-output flip-flop and counts ones over a window of 2^OSR_LOG2 enabled clocks. Each window yields one unsigned sample, which it holds in an output register behind a valid/ready handshake for the downstream sample consumer.

## Interface
- OSR_LOG2, 8, log2 of the decimation ratio; window M = 2^OSR_LOG2 enabled cycles; legal range 2..12.
- DW, OSR_LOG2+1, derived constant (not overridable); sample width, covering 0..M.
- CLK  in  1  rising-edge clock, same domain as the bitstream flop.
- CLRbar  in  1  reset, asynchronous, active-high.
- BIT_IN  in  1  modulator bit, registered upstream, sampled every CLK edge.
- EN  in  1  accumulate enable; low pauses the window without losing state.
- START  in  1  synchronous one-cycle pulse that discards the partial window and restarts it.
- DOUT  out  DW  decimated sample (count of ones in the window).
- DVALID  out  1  DOUT holds an unconsumed sample.
- DREADY  in  1  consumer accepts DOUT on an edge where DVALID&&DREADY.
- OVR  out  1  sticky overrun flag; present only with DECIM_OVERRUN_EN.

## Operation
- **Reset values:** state IDLE, acc=0, cnt=0, DOUT=0, DVALID=0, OVR=0. Reset mid-window discards the partial window and any held sample.
- **FSM states:**
  - IDLE: acc and cnt are held at 0; EN=1 → RUN, and the bit on that edge is counted.
  - RUN: on each edge, acc += BIT_IN and cnt += 1; EN=0 → HOLD with no accumulation on that edge.
  - HOLD: acc and cnt frozen; EN=1 → RUN, and the bit on that edge is counted.
- **START:** has priority over accumulation in every state. It sets acc=0 and cnt=0, and the next state is RUN if EN=1, else IDLE. The bit on the START edge is not counted. START does not touch DOUT, DVALID or OVR.
- **Window end:** on an accumulating edge with cnt==M-1, the sample is acc+BIT_IN (DW bits; the range 0..M cannot overflow). On that edge acc→0 and cnt wraps to 0.
- **Output register:**
  - Load: the sample is loaded when DVALID==0, or when DVALID&&DREADY on the same edge (back-to-back accept-and-reload). DVALID=1 after load.
  - Accept without a new sample: DVALID→0, and DOUT keeps its last value.
  - Drop: if DVALID==1 and DREADY==0 at window end, the new sample is dropped, DOUT is unchanged, and OVR is set (if compiled in).
- acc width is DW and cnt width is OSR_LOG2; both are unsigned.

## Timing
- A sample appears on DOUT with DVALID=1 immediately after the edge that counts the M-th enabled bit, giving a latency of 1 edge from the last bit.
- The minimum sample spacing is M cycles. A consumer holding DREADY=1 never causes a drop.
- DVALID must not depend combinationally on DREADY. All outputs are registered.
- START and window end on the same edge: START wins, and no sample is produced.
- EN=0 on the would-be final edge: no sample. The window completes on the next enabled edge.

## Configuration
- DECIM_OVERRUN_EN defined: the OVR port and flag logic exist. OVR is set on a dropped sample and cleared only by CLRbar.
- Undefined: there is no OVR port, and drops are silent. All other behaviour is identical.

## Structure
- Package rd_adc_pkg holds the FSM state typedef (IDLE/RUN/HOLD) and the DW derivation function shared with the other ADC stages.
- Sub-module rd_decim_outreg holds the output register with load/accept/drop logic and the optional OVR. The top level holds the FSM, acc and cnt.

## Test plan
Run the bench with OSR_LOG2=4 (M=16, DW=5).
- BIT_IN=1 constant, EN=1, DREADY=1 → DOUT=5'b10000 every 16 cycles, with the first DVALID 16 edges after EN rises.
- BIT_IN alternating 1,0, EN=1 → DOUT=8. Then BIT_IN=0 → DOUT=0.
- EN low for 5 cycles mid-window with BIT_IN=1 → sample still 16, and DVALID is delayed exactly 5 cycles.
- DREADY=0 across two windows (12 then 3) → DOUT stays 12, and OVR=1 (macro on). Raising DREADY then clears DVALID, and OVR stays 1.
- START pulse at cnt=10 with BIT_IN=1 → the next sample arrives 16 enabled edges after START and equals 16. START coinciding with window end produces no sample.
- CLRbar asserted asynchronously mid-window with DVALID=1 → DVALID/DOUT/OVR go to 0 immediately. After release, the state is IDLE until EN.
